// File: rtl/proc_io_pkg.sv
// Shared types and default sizes for the processor byte I/O device.
package proc_io_pkg;
  localparam int DATA_W_DFLT = 8;
  localparam int DEPTH_DFLT  = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_PRESENT, TX_RELEASE} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_ACKED}               rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with first-word fall-through read, full/empty flags and occupancy count.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic                         push, pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is reset so the fall-through head reads 0 straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/proc_io_device.sv
// Device side of the processor byte I/O port: host FIFOs bridged to two four-phase handshakes.
// Optional transfer counters and overflow flag when PROC_IO_STATS_EN is defined.
module proc_io_device
  import proc_io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int DEPTH  = DEPTH_DFLT,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr_en,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_full,
  output logic [CNT_W-1:0]  host_tx_count,
  input  logic              host_rd_en,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_empty,
  output logic [CNT_W-1:0]  host_rx_count,
  output logic [DATA_W-1:0] in_data,
  output logic              in_data_ready,
  input  logic              in_ack,
  input  logic [DATA_W-1:0] out_data,
  input  logic              out_data_ready,
`ifdef PROC_IO_STATS_EN
  output logic [15:0]       tx_xfer_count,
  output logic [15:0]       rx_xfer_count,
  output logic              rx_overflow_stall,
`endif
  output logic              out_ack
);
  tx_state_t         tx_state, tx_next;
  rx_state_t         rx_state, rx_next;
  logic [DATA_W-1:0] tx_head, in_data_next;
  logic              tx_empty, tx_pop, in_rdy_next;
  logic              rx_full, rx_push, ack_next;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) tx_fifo (
    .clk(clk), .reset(reset),
    .wr_en(host_wr_en), .wr_data(host_wr_data),
    .rd_en(tx_pop), .rd_data(tx_head),
    .full(host_full), .empty(tx_empty), .count(host_tx_count)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) rx_fifo (
    .clk(clk), .reset(reset),
    .wr_en(rx_push), .wr_data(out_data),
    .rd_en(host_rd_en), .rd_data(host_rd_data),
    .full(rx_full), .empty(host_empty), .count(host_rx_count)
  );

  // TX: only start a byte once the processor has dropped its previous ack.
  always_comb begin
    tx_next      = tx_state;
    in_data_next = in_data;
    in_rdy_next  = in_data_ready;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty && !in_ack) begin
        tx_pop       = 1'b1;
        in_data_next = tx_head;
        in_rdy_next  = 1'b1;
        tx_next      = TX_PRESENT;
      end
      TX_PRESENT: if (in_ack) begin
        in_rdy_next = 1'b0;
        tx_next     = TX_RELEASE;
      end
      TX_RELEASE: if (!in_ack) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // RX: capture once per ready pulse; a full FIFO withholds the ack.
  always_comb begin
    rx_next  = rx_state;
    ack_next = out_ack;
    rx_push  = 1'b0;
    case (rx_state)
      RX_IDLE: if (out_data_ready && !rx_full) begin
        rx_push  = 1'b1;
        ack_next = 1'b1;
        rx_next  = RX_ACKED;
      end
      RX_ACKED: if (!out_data_ready) begin
        ack_next = 1'b0;
        rx_next  = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state      <= TX_IDLE;
      rx_state      <= RX_IDLE;
      in_data       <= '0;
      in_data_ready <= 1'b0;
      out_ack       <= 1'b0;
    end else begin
      tx_state      <= tx_next;
      rx_state      <= rx_next;
      in_data       <= in_data_next;
      in_data_ready <= in_rdy_next;
      out_ack       <= ack_next;
    end
  end

`ifdef PROC_IO_STATS_EN
  // The overflow flag only counts as a stall while a fresh byte is waiting to be captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_xfer_count     <= '0;
      rx_xfer_count     <= '0;
      rx_overflow_stall <= 1'b0;
    end else begin
      if (tx_state == TX_PRESENT && in_ack) tx_xfer_count <= tx_xfer_count + 16'd1;
      if (rx_push) rx_xfer_count <= rx_xfer_count + 16'd1;
      if (rx_state == RX_IDLE && out_data_ready && rx_full) rx_overflow_stall <= 1'b1;
    end
  end
`endif
endmodule
